cpu_bus_seq: RTL
================

Name: cpu_bus_seq

Overview:
- Parametrised bus access sequencer for the 65832 CPU core.
- Takes one load/store request of 1, 2, 4 … up to DATA_W/8 bytes and splits it into little-endian byte beats on the external CPU bus (o_bus_clk/o_bus_we/o_bus_addr/o_bus_data, i_bus_data_ready handshake).
- Reassembles read data with zero or sign extension and reports a bus timeout as an error.
- Sits between the CPU execute logic and the system bus; it replaces ad-hoc per-instruction bus driving.

Parameters:
- DATA_W, 32, request data width in bits; multiple of 8, minimum 8.
- ADDR_W, 32, bus address width in bits.
- SIZE_W, 2, width of the size field; beats = 1 << size.
- TMO_W, 8, width of the timeout counter; limit = 2^TMO_W − 1 wait cycles per beat.

Ports:
- i_cpu_clk  in  1  sole clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_req_valid  in  1  request present.
- o_req_ready  out  1  sequencer idle; a request is accepted when i_req_valid && o_req_ready.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_signed  in  1  load only: sign-extend the result.
- i_req_size  in  SIZE_W  log2 of the byte count.
- i_req_addr  in  ADDR_W  byte address of the least-significant byte.
- i_req_wdata  in  DATA_W  store data; byte k is bits [8k+7:8k].
- o_rsp_valid  out  1  one-cycle pulse at completion.
- o_rsp_err  out  1  valid with o_rsp_valid; timeout or illegal size.
- o_rsp_rdata  out  DATA_W  load result; 0 for stores and errors.
- o_bus_clk  out  1  bus strobe.
- o_bus_we  out  1  bus write enable.
- o_bus_addr  out  ADDR_W  bus byte address.
- o_bus_data  out  8  bus write byte.
- i_bus_data  in  8  bus read byte.
- i_bus_data_ready  in  1  target acknowledge; level-sampled.
- o_busy  out  1  high whenever the sequencer is not in IDLE.

Behaviour:
- Reset (i_rst = 0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0 except o_req_ready, which is 1.
  - Internal beat counter, timeout counter and data shift register are cleared.
  - Reset mid-transfer abandons the transfer; no response is emitted.
- States: IDLE, SETUP, STROBE, WAIT, DONE.
- IDLE:
  - o_req_ready = 1.
  - On accept, latch the request.
  - beats = 1 << size.
  - If beats > DATA_W/8: go to DONE with err = 1; no bus cycle occurs.
  - Otherwise go to SETUP with beat index = 0.
- SETUP (1 cycle):
  - o_bus_addr = (addr + index) mod 2^ADDR_W; wrap-around is legal.
  - o_bus_we = we.
  - o_bus_data = wdata byte[index].
  - o_bus_clk = 0.
  - Go to STROBE.
- STROBE (1 cycle):
  - o_bus_clk = 1; addr, data and we are held.
  - Go to WAIT; the timeout counter is cleared.
- WAIT:
  - o_bus_clk stays 1; addr, data and we are held.
  - When i_bus_data_ready = 1:
    - If loading, capture i_bus_data into rdata byte[index].
    - If index == beats − 1, go to DONE; else increment index and go to SETUP.
  - Otherwise increment the timeout counter. When it reaches 2^TMO_W − 1 without ready, go to DONE with err = 1.
  - i_bus_data_ready is ignored in all states other than WAIT.
- DONE (1 cycle):
  - o_rsp_valid = 1; o_bus_clk = 0; o_bus_we = 0.
  - o_rsp_rdata:
    - load, no error: the assembled bytes. Bits above 8·beats are zero-filled, or filled with bit 8·beats−1 when i_req_signed.
    - store or error: 0.
  - Go to IDLE; o_req_ready is 1 in the following cycle.
- Latency: the minimum cycle count from accept to o_rsp_valid is 3·beats + 1 when ready is already high on entry to each WAIT.
- Back-to-back: a request presented the cycle o_req_ready returns high is accepted immediately.
- o_bus_we is only ever 1 in SETUP, STROBE and WAIT of a store.
- o_rsp_rdata and o_rsp_err hold their values until the next DONE. o_rsp_valid is a single-cycle pulse.
- Request inputs are sampled only at accept; changes afterwards have no effect.

Test Plan:
- Byte load:
  - Stimulus: size = 0, addr = 0x1000, i_bus_data = 0x85, signed = 1, ready high.
  - Response: a single beat at 0x1000; rdata = 0xFFFFFF85, err = 0; o_rsp_valid 4 cycles after accept.
- Word store:
  - Stimulus: size = 2, addr = 0x2000, wdata = 0xA1B2C3D4.
  - Response: beats at 0x2000..0x2003 with data D4, C3, B2, A1; o_bus_we = 1 on each; rsp err = 0, rdata = 0.
- Half load with wrap:
  - Stimulus: size = 1, addr = 0xFFFFFFFF, bytes 0x34 then 0x12, signed = 0.
  - Response: beats at 0xFFFFFFFF then 0x00000000; rdata = 0x00001234.
- Timeout:
  - Stimulus: size = 0, ready held low.
  - Response: after 255 WAIT cycles, o_rsp_valid with err = 1 and rdata = 0; o_req_ready returns next cycle.
- Illegal size and reset mid-transfer:
  - Stimulus 1: size = 3 with DATA_W = 32.
  - Response 1: err = 1 with no o_bus_clk pulse.
  - Stimulus 2: assert i_rst low during the WAIT of beat 1 of a word load.
  - Response 2: outputs return to reset values immediately; no o_rsp_valid.
- Stall and back-to-back:
  - Stimulus: ready delayed by 5 cycles on beat 0, then a second request presented on the first ready cycle.
  - Response: the second request is accepted that cycle; the captured byte is correct.

Source files
------------

// File: rtl/cpu_bus_seq.sv
// rtl/cpu_bus_seq.sv - splits CPU load/store requests into byte beats on the external CPU bus
module cpu_bus_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int SIZE_W = 2,
    parameter int TMO_W  = 8
) (
    input  logic              i_cpu_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic              i_req_signed,
    input  logic [SIZE_W-1:0] i_req_size,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic              o_rsp_err,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_bus_clk,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [7:0]        o_bus_data,
    input  logic [7:0]        i_bus_data,
    input  logic              i_bus_data_ready,
    output logic              o_busy
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               we_q, we_d;
    logic               sgn_q, sgn_d;
    logic [SIZE_W-1:0]  size_q, size_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [DATA_W-1:0]  rdata_asm;

    // Replace every byte above the transfer size with zero or the sign bit.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                                 input logic [SIZE_W-1:0] size,
                                                 input logic              sgn);
        logic [DATA_W-1:0] r;
        logic              fill;
        int                nbytes;
        nbytes = 1 << size;
        fill   = sgn & d[8*nbytes-1];
        for (int k = 0; k < NB; k++) begin
            r[8*k +: 8] = (k < nbytes) ? d[8*k +: 8] : {8{fill}};
        end
        return r;
    endfunction

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge i_cpu_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            last_q      <= '0;
            tmo_q       <= '0;
            we_q        <= 1'b0;
            sgn_q       <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            tmo_q       <= tmo_d;
            we_q        <= we_d;
            sgn_q       <= sgn_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next-state, beat sequencing, read assembly and bus drive.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        tmo_d       = tmo_q;
        we_d        = we_q;
        sgn_d       = sgn_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        o_req_ready = 1'b0;
        o_bus_clk   = 1'b0;
        o_bus_we    = 1'b0;
        o_bus_addr  = '0;
        o_bus_data  = '0;

        rdata_asm = rdata_q;
        rdata_asm[8*int'(idx_q) +: 8] = i_bus_data;

        case (state_q)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    sgn_d   = i_req_signed;
                    size_d  = i_req_size;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    rdata_d = '0;
                    idx_d   = '0;
                    last_d  = IDX_W'((64'd1 << i_req_size) - 64'd1);
                    if ((64'd1 << i_req_size) > 64'(NB)) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                o_bus_we   = we_q;
                o_bus_addr = addr_q + ADDR_W'(idx_q);
                o_bus_data = wdata_q[8*int'(idx_q) +: 8];
                state_d    = S_STROBE;
            end
            S_STROBE: begin
                o_bus_clk  = 1'b1;
                o_bus_we   = we_q;
                o_bus_addr = addr_q + ADDR_W'(idx_q);
                o_bus_data = wdata_q[8*int'(idx_q) +: 8];
                tmo_d      = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                o_bus_clk  = 1'b1;
                o_bus_we   = we_q;
                o_bus_addr = addr_q + ADDR_W'(idx_q);
                o_bus_data = wdata_q[8*int'(idx_q) +: 8];
                if (i_bus_data_ready) begin
                    if (!we_q) begin
                        rdata_d = rdata_asm;
                    end
                    if (idx_q == last_q) begin
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = we_q ? '0 : extend(rdata_asm, size_q, sgn_q);
                        state_d     = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SETUP;
                    end
                end else if (tmo_q == TMO_MAX - 1'b1) begin
                    tmo_d       = TMO_MAX;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_rsp_valid = (state_q == S_DONE);
    assign o_rsp_err   = rsp_err_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_busy      = (state_q != S_IDLE);

endmodule
